// File: rtl/iob_eth_tx_queue.sv
// iob_eth_tx_queue
//   Multi-slot transmit frame queue for the Ethernet core. The host or a DMA
//   engine fills word-wide slots and then commits each one as a frame with a
//   byte length. Committed frames go out in order as a byte stream on a
//   valid/ready interface toward the TX MAC. Frames shorter than MIN_BYTES
//   are zero-padded.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   wr_en/addr/data/strb  word write into the current fill slot (tail)
//   commit, commit_len  close the fill slot as a frame of commit_len bytes
//   flush               discard every queued and in-flight frame
//   out_valid/data/last/ready  byte stream toward the MAC
//   frame_done          high in the cycle the last byte of a frame is accepted
//   err                 one-cycle pulse after a rejected commit
//   full, empty, count  occupancy in committed-but-not-yet-sent frames
module iob_eth_tx_queue #(
  parameter int DATA_W      = 32,
  parameter int NSLOTS      = 4,
  parameter int SLOT_ADDR_W = 9,
  parameter int LEN_W       = 11,
  parameter int MIN_BYTES   = 60
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [SLOT_ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic [DATA_W/8-1:0]       wr_strb,
  input  logic                      commit,
  input  logic [LEN_W-1:0]          commit_len,
  input  logic                      flush,
  output logic                      out_valid,
  output logic [7:0]                out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      frame_done,
  output logic                      err,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(NSLOTS):0]   count
);

  localparam int BPW       = DATA_W / 8;
  localparam int SEL_W     = $clog2(BPW);
  localparam int PTR_W     = $clog2(NSLOTS);
  localparam int CNT_W     = PTR_W + 1;
  localparam int RAM_AW    = PTR_W + SLOT_ADDR_W;
  localparam int MAX_BYTES = BPW << SLOT_ADDR_W;

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

  logic [DATA_W-1:0] mem [2**RAM_AW];
  logic [LEN_W-1:0]  len_mem [NSLOTS];
  logic [DATA_W-1:0] ram_rdata;
  logic              rd_en;
  logic [RAM_AW-1:0] rd_addr;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [SLOT_ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [SEL_W-1:0]       byte_sel_q, byte_sel_d;
  logic [LEN_W-1:0]       byte_idx_q, byte_idx_d;
  logic [DATA_W-1:0]      cur_word_q, cur_word_d;
  logic                   out_valid_q, out_valid_d;
  logic [7:0]             out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic                   err_q, err_d;

  logic                   full_w, empty_w, len_bad, commit_ok, wr_ok;
  logic                   accept, pop;
  logic [LEN_W-1:0]       head_len, wire_len, nxt_idx;
  logic [SEL_W-1:0]       nxt_sel;
  logic [DATA_W-1:0]      nxt_word;

  assign full_w   = (count_q == CNT_W'(NSLOTS));
  assign empty_w  = (count_q == '0);
  assign len_bad  = (commit_len == '0) ||
                    ({1'b0, commit_len} > (LEN_W+1)'(MAX_BYTES));
  assign commit_ok = commit && !flush && !full_w && !len_bad;
  assign wr_ok     = wr_en && !flush && !full_w;

  // The head slot's length cannot change while it streams: commits only
  // land in the tail slot, and tail reaches head only when full, where
  // commits are rejected.
  assign head_len = len_mem[head_q];
  assign wire_len = (head_len < LEN_W'(MIN_BYTES)) ? LEN_W'(MIN_BYTES) : head_len;

  // frame_done marks the handshake cycle itself, so a commit in that cycle
  // sees the pop on the same edge and count stays put.
  assign accept = (state_q == STREAM) && out_valid_q && out_ready;
  assign pop    = accept && out_last_q && !flush && rst;

  // Slot storage with byte strobes and a registered read port; the length
  // table sits alongside it and is indexed by slot.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int b = 0; b < BPW; b++) begin
        if (wr_strb[b]) mem[{tail_q, wr_addr}][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (commit_ok) len_mem[tail_q] <= commit_len;
    if (rd_en) ram_rdata <= mem[rd_addr];
  end

  // Next-state logic. The RAM always holds the word after the one being
  // shifted out, so when the last byte of a word is taken the next word is
  // already in ram_rdata and the following read is issued in the same cycle.
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q + PTR_W'(commit_ok);
    count_d     = count_q + CNT_W'(commit_ok) - CNT_W'(pop);
    word_idx_d  = word_idx_q;
    byte_sel_d  = byte_sel_q;
    byte_idx_d  = byte_idx_q;
    cur_word_d  = cur_word_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    err_d       = commit && !flush && (full_w || len_bad);
    rd_en       = 1'b0;
    rd_addr     = {head_q, word_idx_q};
    nxt_idx     = byte_idx_q + LEN_W'(1);
    nxt_sel     = byte_sel_q + SEL_W'(1);
    nxt_word    = cur_word_q;

    case (state_q)
      IDLE: begin
        if (!empty_w) begin
          rd_en      = 1'b1;
          rd_addr    = {head_q, {SLOT_ADDR_W{1'b0}}};
          word_idx_d = SLOT_ADDR_W'(1);
          byte_idx_d = '0;
          byte_sel_d = '0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        cur_word_d  = ram_rdata;
        rd_en       = 1'b1;
        word_idx_d  = word_idx_q + SLOT_ADDR_W'(1);
        out_valid_d = 1'b1;
        out_data_d  = ram_rdata[7:0];
        out_last_d  = (wire_len == LEN_W'(1));
        state_d     = STREAM;
      end
      STREAM: begin
        if (accept) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = 8'h00;
            head_d      = head_q + PTR_W'(1);
            state_d     = IDLE;
          end else begin
            if (byte_sel_q == SEL_W'(BPW-1)) begin
              nxt_sel    = '0;
              nxt_word   = ram_rdata;
              rd_en      = 1'b1;
              word_idx_d = word_idx_q + SLOT_ADDR_W'(1);
            end
            byte_idx_d = nxt_idx;
            byte_sel_d = nxt_sel;
            cur_word_d = nxt_word;
            // Bytes past the committed length are padding.
            out_data_d = (nxt_idx >= head_len) ? 8'h00 : nxt_word[{nxt_sel, 3'b000} +: 8];
            out_last_d = (nxt_idx == wire_len - LEN_W'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d     = IDLE;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_data_d  = 8'h00;
      err_d       = 1'b0;
      rd_en       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      word_idx_q  <= '0;
      byte_sel_q  <= '0;
      byte_idx_q  <= '0;
      cur_word_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      byte_sel_q  <= byte_sel_d;
      byte_idx_q  <= byte_idx_d;
      cur_word_q  <= cur_word_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign frame_done = pop;
  assign err        = err_q;
  assign full       = full_w;
  assign empty      = empty_w;
  assign count      = count_q;

endmodule

// File: tb/tb_iob_eth_tx_queue.sv
// Directed bench for iob_eth_tx_queue: frame streaming, padding, stalls,
// full/err handling, commit on frame_done, flush and mid-frame reset.
module tb_iob_eth_tx_queue;

   logic        clock;
   logic        rst;
   logic        wrEn;
   logic [8:0]  wrAddr;
   logic [31:0] wrData;
   logic [3:0]  wrStrb;
   logic        commit;
   logic [11:0] commitLen;
   logic        flush;
   logic        outValid;
   logic [7:0]  outData;
   logic        outLast;
   logic        outReady;
   logic        frameDone;
   logic        err;
   logic        full;
   logic        empty;
   logic [2:0]  count;

   int numCompared = 0;
   int numMismatched = 0;
   logic [7:0] expBytes [0:127];

   iob_eth_tx_queue #(
      .DATA_W(32), .NSLOTS(4), .SLOT_ADDR_W(9), .LEN_W(12), .MIN_BYTES(60)
   ) dut (
      .clk(clock), .rst(rst),
      .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .wr_strb(wrStrb),
      .commit(commit), .commit_len(commitLen), .flush(flush),
      .out_valid(outValid), .out_data(outData), .out_last(outLast),
      .out_ready(outReady), .frame_done(frameDone), .err(err),
      .full(full), .empty(empty), .count(count)
   );

   // Free-running clock with a 10 ns period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Hard stop in case something wedges outside the bounded loops.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Counts one comparison and reports it when observed differs from expected.
   task automatic checkOutput(input string tag, input int got, input int exp);
      numCompared++;
      if (got !== exp) begin
         numMismatched++;
         $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Advance one clock and settle away from the edge.
   task automatic step();
      @(posedge clock);
      #2;
   endtask

   // Pulse commit for one cycle with the given length.
   task automatic applyStimulus(input int len);
      commit = 1'b1;
      commitLen = 12'(len);
      step();
      commit = 1'b0;
   endtask

   task automatic writeWord(input int addr, input logic [31:0] data, input logic [3:0] strb);
      wrEn = 1'b1;
      wrAddr = 9'(addr);
      wrData = data;
      wrStrb = strb;
      step();
      wrEn = 1'b0;
   endtask

   // Words whose bytes are their own byte index: 0x03020100, 0x07060504, ...
   task automatic writePattern(input int nWords);
      for (int i = 0; i < nWords; i++)
         writeWord(i, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 4'hF);
   endtask

   task automatic setExpPattern(input int len, input int n);
      for (int i = 0; i < n; i++) expBytes[i] = (i < len) ? 8'(i) : 8'h00;
   endtask

   // Receives n bytes, optionally toggling out_ready every cycle, and
   // checks data, out_last placement, hold-while-stalled and frame_done.
   task automatic receiveFrame(input int n, input bit toggle, input string name);
      int got = 0;
      int cyc = 0;
      int dataBad = 0;
      int lastBad = 0;
      int holdBad = 0;
      int doneCnt = 0;
      int firstBad = -1;
      bit stalled = 0;
      logic [7:0] prevData = 8'h00;
      logic prevLast = 1'b0;
      while (got < n && cyc < 2000) begin
         outReady = toggle ? ((cyc % 2) == 0) : 1'b1;
         #1;
         if (outValid) begin
            if (stalled && (outData !== prevData || outLast !== prevLast)) holdBad++;
            if (outReady) begin
               if (outData !== expBytes[got]) begin
                  dataBad++;
                  if (firstBad < 0) firstBad = got;
               end
               if (outLast !== (got == n-1)) lastBad++;
               if (frameDone) doneCnt++;
               got++;
               stalled = 0;
            end else begin
               stalled = 1;
               prevData = outData;
               prevLast = outLast;
            end
         end
         @(posedge clock);
         #1;
         cyc++;
      end
      #1;
      outReady = 1'b1;
      checkOutput({name, "_bytes"}, got, n);
      checkOutput({name, "_dataErrs"}, dataBad, 0);
      if (dataBad != 0) $display("[TB] first bad byte index in %s: %0d", name, firstBad);
      checkOutput({name, "_lastErrs"}, lastBad, 0);
      checkOutput({name, "_holdErrs"}, holdBad, 0);
      checkOutput({name, "_frameDone"}, doneCnt, 1);
   endtask

   initial begin
      int found;
      int cntBefore;
      int doneNow;
      int idx;
      int dataBad;
      int lastSeen;
      int doneSeen;
      int validCnt;

      rst = 1'b0; wrEn = 1'b0; wrAddr = '0; wrData = '0; wrStrb = '0;
      commit = 1'b0; commitLen = '0; flush = 1'b0; outReady = 1'b1;

      // Reset values.
      step(); step();
      checkOutput("rst_outValid", int'(outValid), 0);
      checkOutput("rst_outData", int'(outData), 0);
      checkOutput("rst_outLast", int'(outLast), 0);
      checkOutput("rst_err", int'(err), 0);
      checkOutput("rst_empty", int'(empty), 1);
      checkOutput("rst_full", int'(full), 0);
      checkOutput("rst_count", int'(count), 0);
      rst = 1'b1;
      step();

      // 64-byte frame of bytes 0x00..0x3F, with first-byte latency.
      writePattern(16);
      applyStimulus(64);
      checkOutput("t1_count", int'(count), 1);
      checkOutput("t1_validAtCommit", int'(outValid), 0);
      step();
      checkOutput("t1_validPlus1", int'(outValid), 0);
      step();
      checkOutput("t1_validPlus2", int'(outValid), 1);
      setExpPattern(64, 64);
      receiveFrame(64, 0, "t1");
      checkOutput("t1_emptyAfter", int'(empty), 1);

      // Short frame with partial-strobe writes and padding to 60 bytes.
      writeWord(0, 32'hDDCCBBAA, 4'hF);
      writeWord(1, 32'h00005544, 4'hF);
      writeWord(1, 32'h77660000, 4'hC);
      writeWord(2, 32'hEEFF9988, 4'hF);
      applyStimulus(10);
      for (int i = 0; i < 60; i++) expBytes[i] = 8'h00;
      expBytes[0] = 8'hAA; expBytes[1] = 8'hBB; expBytes[2] = 8'hCC; expBytes[3] = 8'hDD;
      expBytes[4] = 8'h44; expBytes[5] = 8'h55; expBytes[6] = 8'h66; expBytes[7] = 8'h77;
      expBytes[8] = 8'h88; expBytes[9] = 8'h99;
      receiveFrame(60, 0, "t2");

      // Same 64-byte content with out_ready toggling every cycle.
      writePattern(16);
      applyStimulus(64);
      setExpPattern(64, 64);
      receiveFrame(64, 1, "t3");

      // Fill all four slots while the sink is stalled.
      outReady = 1'b0;
      writePattern(3);
      applyStimulus(12);
      applyStimulus(8);
      applyStimulus(8);
      applyStimulus(8);
      checkOutput("t4_full", int'(full), 1);
      checkOutput("t4_count", int'(count), 4);
      applyStimulus(8);
      checkOutput("t4_errOnFull", int'(err), 1);
      checkOutput("t4_countAfterErr", int'(count), 4);
      step();
      checkOutput("t4_errPulse", int'(err), 0);
      writeWord(2, 32'hFFFFFFFF, 4'hF);
      checkOutput("t4_countAfterWr", int'(count), 4);
      setExpPattern(12, 60);
      receiveFrame(60, 0, "t4a");
      setExpPattern(8, 60);
      receiveFrame(60, 0, "t4b");
      for (int i = 0; i < 60; i++) expBytes[i] = 8'h00;
      expBytes[0] = 8'hAA; expBytes[1] = 8'hBB; expBytes[2] = 8'hCC; expBytes[3] = 8'hDD;
      expBytes[4] = 8'h44; expBytes[5] = 8'h55; expBytes[6] = 8'h66; expBytes[7] = 8'h77;
      receiveFrame(60, 0, "t4c");
      setExpPattern(8, 60);
      receiveFrame(60, 0, "t4d");
      checkOutput("t4_emptyAfter", int'(empty), 1);

      // Commit in the same cycle as frame_done: count stays 1.
      applyStimulus(60);
      found = 0; cntBefore = -1; doneNow = -1;
      for (int c = 0; c < 200 && found == 0; c++) begin
         outReady = 1'b1;
         #1;
         if (outValid && outLast) begin
            doneNow = int'(frameDone);
            cntBefore = int'(count);
            commit = 1'b1;
            commitLen = 12'd8;
            found = 1;
         end
         step();
         commit = 1'b0;
      end
      checkOutput("t5_found", found, 1);
      checkOutput("t5_doneInCycle", doneNow, 1);
      checkOutput("t5_countBefore", cntBefore, 1);
      checkOutput("t5_countAfter", int'(count), 1);
      checkOutput("t5_err", int'(err), 0);
      setExpPattern(8, 60);
      receiveFrame(60, 0, "t5next");

      // Flush on byte 20 of a 100-byte frame with two more queued.
      writePattern(25);
      applyStimulus(100);
      applyStimulus(8);
      applyStimulus(8);
      checkOutput("t6_count", int'(count), 3);
      idx = 0; dataBad = 0; lastSeen = 0; doneSeen = 0; found = 0;
      for (int c = 0; c < 200 && found == 0; c++) begin
         outReady = 1'b1;
         #1;
         if (outValid) begin
            if (outData !== 8'(idx)) dataBad++;
            if (outLast) lastSeen++;
            if (frameDone) doneSeen++;
            if (idx == 20) begin
               flush = 1'b1;
               found = 1;
            end
            idx++;
         end
         step();
         flush = 1'b0;
      end
      checkOutput("t6_reached20", found, 1);
      checkOutput("t6_dataErrs", dataBad, 0);
      checkOutput("t6_validAfter", int'(outValid), 0);
      checkOutput("t6_empty", int'(empty), 1);
      checkOutput("t6_countAfter", int'(count), 0);
      validCnt = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (outValid) validCnt++;
         if (outLast) lastSeen++;
         if (frameDone) doneSeen++;
         step();
      end
      checkOutput("t6_noLast", lastSeen, 0);
      checkOutput("t6_noFrameDone", doneSeen, 0);
      checkOutput("t6_staysIdle", validCnt, 0);

      // Length boundaries.
      applyStimulus(0);
      checkOutput("t7_errLen0", int'(err), 1);
      checkOutput("t7_countLen0", int'(count), 0);
      applyStimulus(2049);
      checkOutput("t7_errLen2049", int'(err), 1);
      checkOutput("t7_countLen2049", int'(count), 0);
      applyStimulus(2048);
      checkOutput("t7_errLen2048", int'(err), 0);
      checkOutput("t7_countLen2048", int'(count), 1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      checkOutput("t7_countFlush", int'(count), 0);

      // Reset in the middle of a frame.
      outReady = 1'b0;
      applyStimulus(60);
      step(); step(); step();
      checkOutput("t8_validBefore", int'(outValid), 1);
      rst = 1'b0;
      step();
      checkOutput("t8_valid", int'(outValid), 0);
      checkOutput("t8_data", int'(outData), 0);
      checkOutput("t8_count", int'(count), 0);
      checkOutput("t8_empty", int'(empty), 1);
      rst = 1'b1;
      step(); step(); step();
      checkOutput("t8_validLater", int'(outValid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
